// File: rtl/buffer_fill_ctrl_pkg.sv
// Shared constants and helpers for the operand-buffer fill/drain controller.
// Holds the default TensorCore widths, the derived pack ratio and the
// pointer-increment helper used by the write and read pointers.
package buffer_fill_ctrl_pkg;

  // Default TensorCore operand-buffer geometry.
  localparam int unsigned DEF_DATA_WIDTH   = 128;
  localparam int unsigned DEF_IN_WIDTH     = 32;
  localparam int unsigned DEF_BUFFER_DEPTH = 2;
  localparam int unsigned DEF_ADDR_WIDTH   = 1;
  localparam int unsigned DEF_CNT_WIDTH    = 16;

  // Beats per buffer word and the beat counter width for the defaults.
  localparam int unsigned RATIO      = DEF_DATA_WIDTH / DEF_IN_WIDTH;
  localparam int unsigned BEAT_CNT_W = $clog2(RATIO);

  // Next entry index, wrapping from depth-1 back to 0.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/buffer_fill_ctrl_packer.sv
// Beat packer: gathers DATA_WIDTH/IN_WIDTH narrow beats into one word.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clear           synchronous flush of the partial word
//   in_valid/in_ready/in_data  narrow beat handshake (in_ready = !pack_full)
//   word_taken      the packed word was written into the buffer this cycle
//   pack_full       pack_reg holds a complete word awaiting a free entry
//   pack_reg        packed word, beat 0 in the LSBs
module buffer_fill_ctrl_packer
  import buffer_fill_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  word_taken,
  output logic                  pack_full,
  output logic [DATA_WIDTH-1:0] pack_reg
);

  localparam int unsigned PACK_RATIO = DATA_WIDTH / IN_WIDTH;
  localparam int unsigned PACK_CNT_W = $clog2(PACK_RATIO);

  logic [PACK_CNT_W-1:0] beat_cnt;
  logic                  accept_c;

  assign accept_c = in_valid && !pack_full;
  assign in_ready = !pack_full;

  // Beat slotting; accept and word_taken are mutually exclusive via pack_full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      pack_full <= 1'b0;
      pack_reg  <= '0;
    end else if (clear) begin
      beat_cnt  <= '0;
      pack_full <= 1'b0;
      pack_reg  <= '0;
    end else begin
      if (accept_c) begin
        pack_reg[32'(beat_cnt) * IN_WIDTH +: IN_WIDTH] <= in_data;
        if (beat_cnt == PACK_CNT_W'(PACK_RATIO - 1)) begin
          beat_cnt  <= '0;
          pack_full <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + PACK_CNT_W'(1);
        end
      end
      if (word_taken) begin
        pack_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/buffer_fill_ctrl.sv
// Fill/drain controller in front of the TensorCore operand buffer.
// Packs narrow beats into buffer words, writes them round-robin into
// BUFFER_DEPTH entries and presents occupied entries in write order until
// the consumer releases them.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   clear                    synchronous flush of all state
//   in_valid/in_ready/in_data  narrow beat stream from memory
//   buf_wr_en/buf_wr_addr/buf_data  buffer write port
//   buf_rd_en/buf_rd_addr    buffer read port
//   out_valid/out_release    consumer handshake for the head entry
//   full/empty               entry occupancy status
//   word_cnt                 words written since reset/clear (wrapping)
//   err_release              sticky: release seen with no valid entry
module buffer_fill_ctrl
  import buffer_fill_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned IN_WIDTH     = DEF_IN_WIDTH,
  parameter int unsigned BUFFER_DEPTH = DEF_BUFFER_DEPTH,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [DATA_WIDTH-1:0] buf_data,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  output logic                  out_valid,
  input  logic                  out_release,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  err_release
);

  logic                    pack_full;
  logic [DATA_WIDTH-1:0]   pack_reg;
  logic [BUFFER_DEPTH-1:0] entry_valid;
  logic [BUFFER_DEPTH-1:0] entry_valid_nxt;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic                    write_fire;
  logic                    rel_fire;

  buffer_fill_ctrl_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IN_WIDTH   (IN_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .word_taken (write_fire),
    .pack_full  (pack_full),
    .pack_reg   (pack_reg)
  );

  // Write only into a free entry; release only an occupied head entry.
  assign write_fire = pack_full && !entry_valid[wr_ptr];
  assign rel_fire   = out_release && out_valid;

  // Everything below is a function of registers only.
  assign buf_wr_en   = write_fire;
  assign buf_wr_addr = wr_ptr;
  assign buf_data    = pack_reg;
  assign out_valid   = entry_valid[rd_ptr];
  assign buf_rd_en   = out_valid;
  assign buf_rd_addr = rd_ptr;
  assign full        = &entry_valid;
  assign empty       = ~|entry_valid;

  // Write and release never hit the same entry, so both updates apply.
  always_comb begin
    entry_valid_nxt = entry_valid;
    if (write_fire) begin
      entry_valid_nxt[wr_ptr] = 1'b1;
    end
    if (rel_fire) begin
      entry_valid_nxt[rd_ptr] = 1'b0;
    end
  end

  // Entry flags, pointers, word counter and release-error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_valid <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      word_cnt    <= '0;
      err_release <= 1'b0;
    end else if (clear) begin
      entry_valid <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      word_cnt    <= '0;
      err_release <= 1'b0;
    end else begin
      entry_valid <= entry_valid_nxt;
      if (write_fire) begin
        wr_ptr   <= ADDR_WIDTH'(ptr_next(32'(wr_ptr), BUFFER_DEPTH));
        word_cnt <= word_cnt + CNT_WIDTH'(1);
      end
      if (rel_fire) begin
        rd_ptr <= ADDR_WIDTH'(ptr_next(32'(rd_ptr), BUFFER_DEPTH));
      end
      if (out_release && !out_valid) begin
        err_release <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_buffer_fill_ctrl.sv
// Scoreboard bench for buffer_fill_ctrl: directed scenarios plus random
// traffic, checked every cycle against a queue-based reference model.
module tb_buffer_fill_ctrl;

  localparam int unsigned DW    = 128;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 1;
  localparam int unsigned CW    = 16;
  localparam int unsigned R     = DW / IW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic [DW-1:0] buf_data;
  logic          buf_rd_en;
  logic [AW-1:0] buf_rd_addr;
  logic          out_valid;
  logic          out_release = 1'b0;
  logic          full;
  logic          empty;
  logic [CW-1:0] word_cnt;
  logic          err_release;

  buffer_fill_ctrl #(
    .DATA_WIDTH(DW), .IN_WIDTH(IW), .BUFFER_DEPTH(DEPTH),
    .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_data(buf_data),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .out_valid(out_valid), .out_release(out_release),
    .full(full), .empty(empty), .word_cnt(word_cnt), .err_release(err_release)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: beats in flight, packed word awaiting an entry,
  // words resident in the buffer (in write order), totals and error flag.
  logic [IW-1:0] part[$];
  logic [DW-1:0] pend[$];
  logic [DW-1:0] occ[$];
  int            n_wr = 0;
  int            n_rd = 0;
  bit            m_err = 1'b0;
  bit            sending;

  function automatic void chk(input string nm, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    part.delete();
    pend.delete();
    occ.delete();
    n_wr  = 0;
    n_rd  = 0;
    m_err = 1'b0;
  endfunction

  // Monitor: compare against pre-edge model state, then advance the model.
  always @(negedge clk) begin : mon
    int            pn;
    int            on;
    bit            wen;
    logic [DW-1:0] w;
    if (rst) begin
      model_reset();
    end else begin
      pn  = pend.size();
      on  = occ.size();
      wen = (pn != 0) && (on < DEPTH);
      chk("in_ready", DW'(in_ready), DW'(pn == 0));
      chk("buf_wr_en", DW'(buf_wr_en), DW'(wen));
      if (wen) begin
        chk("buf_wr_addr", DW'(buf_wr_addr), DW'(n_wr % DEPTH));
        chk("buf_data", buf_data, pend[0]);
      end
      chk("out_valid", DW'(out_valid), DW'(on != 0));
      chk("buf_rd_en", DW'(buf_rd_en), DW'(on != 0));
      if (on != 0) chk("buf_rd_addr", DW'(buf_rd_addr), DW'(n_rd % DEPTH));
      chk("full", DW'(full), DW'(on == DEPTH));
      chk("empty", DW'(empty), DW'(on == 0));
      chk("word_cnt", DW'(word_cnt), DW'(CW'(n_wr)));
      chk("err_release", DW'(err_release), DW'(m_err));
      if (clear) begin
        model_reset();
      end else begin
        if (out_release) begin
          if (on != 0) begin
            void'(occ.pop_front());
            n_rd++;
          end else begin
            m_err = 1'b1;
          end
        end
        if (wen) begin
          occ.push_back(pend.pop_front());
          n_wr++;
        end
        if (in_valid && pn == 0) begin
          part.push_back(in_data);
          if (part.size() == R) begin
            w = '0;
            for (int i = 0; i < R; i++) w[i*IW +: IW] = part[i];
            part.delete();
            pend.push_back(w);
          end
        end
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_beat(input logic [IW-1:0] d);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_beat_timeout: in_ready stayed 0 at %0t", $time);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic pulse_release();
    out_release = 1'b1;
    step();
    out_release = 1'b0;
  endtask

  task automatic drain();
    repeat (8) begin
      out_release = out_valid;
      step();
    end
    out_release = 1'b0;
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset in the middle of packing discards the partial word.
    send_beat(32'hDEAD0001);
    send_beat(32'hDEAD0002);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", DW'(in_ready), DW'(1));
    chk("rst_empty", DW'(empty), DW'(1));
    chk("rst_word_cnt", DW'(word_cnt), DW'(0));
    step();

    // Single word, beat 0 in the LSBs, written one cycle after the last beat.
    send_beat(32'h11111111);
    send_beat(32'h22222222);
    send_beat(32'h33333333);
    send_beat(32'h44444444);
    @(negedge clk);
    chk("single_wr_en", DW'(buf_wr_en), DW'(1));
    chk("single_addr", DW'(buf_wr_addr), DW'(0));
    chk("single_data", buf_data, 128'h44444444_33333333_22222222_11111111);
    step();
    @(negedge clk);
    chk("single_out_valid", DW'(out_valid), DW'(1));
    step();
    pulse_release();

    // Fill to full with a third word held back until an entry frees.
    do_clear();
    for (int i = 0; i < 12; i++) send_beat(32'h1000 + 32'(i));
    idle(2);
    @(negedge clk);
    chk("fill_full", DW'(full), DW'(1));
    chk("fill_in_ready", DW'(in_ready), DW'(0));
    chk("fill_word_cnt", DW'(word_cnt), DW'(2));
    step();
    pulse_release();
    @(negedge clk);
    chk("fill_third_wr_en", DW'(buf_wr_en), DW'(1));
    chk("fill_third_addr", DW'(buf_wr_addr), DW'(0));
    step();
    drain();

    // Write into entry 1 while releasing entry 0 in the same cycle.
    do_clear();
    for (int i = 0; i < R; i++) send_beat($urandom);
    idle(2);
    for (int i = 0; i < R; i++) send_beat($urandom);
    pulse_release();
    @(negedge clk);
    chk("simul_out_valid", DW'(out_valid), DW'(1));
    chk("simul_rd_addr", DW'(buf_rd_addr), DW'(1));
    chk("simul_full", DW'(full), DW'(0));
    chk("simul_empty", DW'(empty), DW'(0));
    step();
    drain();

    // Spurious release sets a sticky error; clear wipes it and partial beats.
    do_clear();
    pulse_release();
    @(negedge clk);
    chk("err_set", DW'(err_release), DW'(1));
    step();
    idle(3);
    @(negedge clk);
    chk("err_sticky", DW'(err_release), DW'(1));
    step();
    send_beat(32'hBAD00001);
    send_beat(32'hBAD00002);
    do_clear();
    @(negedge clk);
    chk("clear_err", DW'(err_release), DW'(0));
    chk("clear_empty", DW'(empty), DW'(1));
    step();
    send_beat(32'hAAAAAAAA);
    send_beat(32'hBBBBBBBB);
    send_beat(32'hCCCCCCCC);
    send_beat(32'hDDDDDDDD);
    @(negedge clk);
    chk("clear_data", buf_data, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    chk("clear_addr", DW'(buf_wr_addr), DW'(0));
    step();
    drain();

    // Streaming: ten words with the consumer releasing as soon as valid.
    do_clear();
    sending = 1'b1;
    fork
      begin
        for (int i = 0; i < 10 * R; i++) send_beat($urandom);
        sending = 1'b0;
      end
      begin
        while (sending) begin
          out_release = out_valid;
          step();
        end
        out_release = 1'b0;
      end
    join
    drain();
    @(negedge clk);
    chk("stream_word_cnt", DW'(word_cnt), DW'(10));
    step();

    // Random traffic with gaps, random releases and occasional spurious ones.
    sending = 1'b1;
    fork
      begin
        for (int i = 0; i < 240; i++) begin
          if ($urandom_range(0, 3) == 0) step();
          send_beat($urandom);
        end
        sending = 1'b0;
      end
      begin
        while (sending) begin
          out_release = ($urandom_range(0, 15) == 0) ? 1'b1
                        : (out_valid && ($urandom_range(0, 1) == 1));
          step();
        end
        out_release = 1'b0;
      end
    join
    drain();
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
